// File: rtl/mio_pkg.sv
// Shared state encoding, address-map constants and decode types for the MIO bus controller.
package mio_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RAM_ACC = 2'd1,
    DONE    = 2'd2
  } mio_state_e;

  localparam logic [3:0]  REG_RAM = 4'h0;
  localparam logic [3:0]  REG_LED = 4'hE;
  localparam logic [3:0]  REG_IO  = 4'hF;

  localparam logic [27:0] SW_OFS  = 28'h000_0000;
  localparam logic [27:0] CNT_OFS = 28'h000_0004;

  typedef struct packed {
    logic ram;
    logic led;
    logic sw;
    logic cnt;
    logic unmapped;
  } mio_sel_t;

  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mio_addr_dec.sv
// Combinational address decoder: one-hot region select, with misaligned or
// unclaimed addresses folded into the unmapped flag.
module mio_addr_dec
  import mio_pkg::*;
#(
  parameter bit CNT_EN = 1'b0
) (
  input  logic [31:0] addr,
  output mio_sel_t    sel
);

  logic [3:0]  region_s;
  logic [27:0] ofs_s;
  logic        aligned_s;

  assign region_s  = addr[31:28];
  assign ofs_s     = addr[27:0];
  assign aligned_s = is_word_aligned(addr);

  // Region decode; anything not claimed by a region is reported as unmapped
  always_comb begin
    sel = '0;
    if (aligned_s) begin
      case (region_s)
        REG_RAM: sel.ram = 1'b1;
        REG_LED: sel.led = 1'b1;
        REG_IO: begin
          if (ofs_s == SW_OFS) begin
            sel.sw = 1'b1;
          end else if (CNT_EN && (ofs_s == CNT_OFS)) begin
            sel.cnt = 1'b1;
          end else begin
            sel.unmapped = 1'b1;
          end
        end
        default: sel.unmapped = 1'b1;
      endcase
    end else begin
      sel.unmapped = 1'b1;
    end
  end

endmodule

// File: rtl/mio_bus_ctrl.sv
// Memory/IO bus controller behind the single-cycle CPU: RAM with fixed wait states,
// LED register, switch input. Define MIO_CYCLE_COUNTER_EN to add the cycle counter at 0xF000_0004.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int RAM_AW   = 10,
  parameter int RAM_WAIT = 1,
  parameter int LED_W    = 16,
  parameter int SW_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic              bus_err,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

`ifdef MIO_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam logic [2:0] RAM_WAIT_C = 3'(RAM_WAIT);

  mio_state_e  state_r;
  mio_state_e  state_nxt_s;
  logic [2:0]  wait_cnt_r;
  logic        we_r;
  logic        accept_s;
  mio_sel_t    sel_s;
  logic [31:0] io_rdata_s;
  logic [31:0] led_ext_s;
  logic [31:0] sw_ext_s;
  logic [31:0] cnt_val_s;

  mio_addr_dec #(
    .CNT_EN (CNT_EN)
  ) u_addr_dec (
    .addr (cpu_addr),
    .sel  (sel_s)
  );

  assign accept_s  = (state_r == IDLE) && cpu_req;
  assign led_ext_s = 32'(led_out);
  assign sw_ext_s  = 32'(sw_in);

`ifdef MIO_CYCLE_COUNTER_EN
  logic [31:0] cnt_r;

  // Free-running cycle counter, wraps naturally at 2**32
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_r <= 32'h0000_0000;
    end else begin
      cnt_r <= cnt_r + 32'h0000_0001;
    end
  end

  assign cnt_val_s = cnt_r;
`else
  assign cnt_val_s = 32'h0000_0000;
`endif

  // Read-data source for single-cycle IO accesses; unmapped reads return zero
  always_comb begin
    io_rdata_s = 32'h0000_0000;
    if (sel_s.led) begin
      io_rdata_s = led_ext_s;
    end else if (sel_s.sw) begin
      io_rdata_s = sw_ext_s;
    end else if (sel_s.cnt) begin
      io_rdata_s = cnt_val_s;
    end else begin
      io_rdata_s = 32'h0000_0000;
    end
  end

  // Next-state logic: RAM goes through the wait-state phase, everything else completes directly
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          state_nxt_s = sel_s.ram ? RAM_ACC : DONE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RAM_ACC: begin
        if (wait_cnt_r == 3'd0) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RAM_ACC;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, datapath and output registers; outputs are set on the edge entering their state
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r    <= IDLE;
      wait_cnt_r <= 3'd0;
      we_r       <= 1'b0;
      cpu_rdata  <= 32'h0000_0000;
      cpu_ready  <= 1'b0;
      bus_err    <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= 32'h0000_0000;
      led_out    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      cpu_ready <= (state_nxt_s == DONE);
      ram_en    <= (state_nxt_s == RAM_ACC);
      bus_err   <= accept_s & sel_s.unmapped;
      if (accept_s) begin
        we_r       <= cpu_we;
        wait_cnt_r <= RAM_WAIT_C;
        if (sel_s.ram) begin
          ram_addr  <= cpu_addr[RAM_AW+1:2];
          ram_wdata <= cpu_wdata;
          ram_we    <= cpu_we;
        end else begin
          ram_we <= 1'b0;
          if (!cpu_we) begin
            cpu_rdata <= io_rdata_s;
          end
          if (cpu_we && sel_s.led) begin
            led_out <= cpu_wdata[LED_W-1:0];
          end
        end
      end else if (state_r == RAM_ACC) begin
        if (wait_cnt_r == 3'd0) begin
          ram_we <= 1'b0;
          if (!we_r) begin
            cpu_rdata <= ram_rdata;
          end
        end else begin
          wait_cnt_r <= wait_cnt_r - 3'd1;
        end
      end
    end
  end

endmodule
